// File: rtl/mc_cpu_core_if.sv
// Memory-side bundle for mc_cpu_core: instruction fetch port and data load/store port.
// Latency: none, wires only.
// Backpressure: each req is held with stable address/data until its ready is sampled high.
// Ports (master = core side):
//   imem_req/imem_addr out, imem_rdata/imem_ready in
//   dmem_req/dmem_we/dmem_addr/dmem_wdata out, dmem_rdata/dmem_ready in
interface mc_cpu_core_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            imem_ready;
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [XLEN-1:0] dmem_rdata;
    logic            dmem_ready;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_rdata, imem_ready, dmem_rdata, dmem_ready
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_rdata, imem_ready, dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/mc_cpu_core.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB FSM with PC, IR, A, B, ALUOut, MDR and a 32-entry register file.
// Latency (zero-wait memory): beq 3, R-type/addi/andi/ori 4, sw 4, lw 5 cycles; each memory wait cycle adds one.
// Backpressure: FETCH and MEM stall with req held high until imem_ready/dmem_ready is sampled.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes enter HALT (halted=1) instead of retiring as a NOP.
// Ports: clk, rst_n (async active-low); mem (mc_cpu_core_if.master) carries both memory handshakes;
//        pc_o = current PC, retire = registered one-cycle completion pulse, halted = core stopped.
module mc_cpu_core #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    mc_cpu_core_if.master   mem,
    output logic [XLEN-1:0] pc_o,
    output logic            retire,
    output logic            halted
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_run;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_aluout;
    logic [XLEN-1:0] r_mdr;
    logic            r_retire;
    logic [XLEN-1:0] r_regs [32];

    logic [5:0]      w_opcode;
    logic [4:0]      w_rs;
    logic [4:0]      w_rt;
    logic [4:0]      w_rd;
    logic [4:0]      w_shamt;
    logic [5:0]      w_funct;
    logic [15:0]     w_imm;
    logic [XLEN-1:0] w_simm;
    logic [XLEN-1:0] w_zimm;
    logic            w_legal;
    logic            w_fn_known;
    logic            w_wen;
    logic [4:0]      w_dst;
    logic [XLEN-1:0] w_alu;
    logic            w_done;

    assign w_opcode = r_ir[31:26];
    assign w_rs     = r_ir[25:21];
    assign w_rt     = r_ir[20:16];
    assign w_rd     = r_ir[15:11];
    assign w_shamt  = r_ir[10:6];
    assign w_funct  = r_ir[5:0];
    assign w_imm    = r_ir[15:0];
    assign w_simm   = XLEN'($signed(w_imm));
    assign w_zimm   = XLEN'(w_imm);

    assign w_legal = (w_opcode == OP_R)    || (w_opcode == OP_BEQ) ||
                     (w_opcode == OP_ADDI) || (w_opcode == OP_ANDI) ||
                     (w_opcode == OP_ORI)  || (w_opcode == OP_LW)  ||
                     (w_opcode == OP_SW);

    assign w_fn_known = (w_funct == FN_ADD) || (w_funct == FN_SUB) ||
                        (w_funct == FN_AND) || (w_funct == FN_OR)  ||
                        (w_funct == FN_SLT) || (w_funct == FN_SLL) ||
                        (w_funct == FN_SRL);

    // Unknown R-type functs still pass through WB so they retire, but write nothing.
    assign w_wen = (w_opcode == OP_R) ? w_fn_known : 1'b1;
    assign w_dst = (w_opcode == OP_R) ? w_rd : w_rt;

    always_comb begin
        w_alu = '0;
        case (w_opcode)
            OP_R: begin
                case (w_funct)
                    FN_ADD:  w_alu = r_a + r_b;
                    FN_SUB:  w_alu = r_a - r_b;
                    FN_AND:  w_alu = r_a & r_b;
                    FN_OR:   w_alu = r_a | r_b;
                    FN_SLT:  w_alu = XLEN'($signed(r_a) < $signed(r_b));
                    FN_SLL:  w_alu = r_b << w_shamt;
                    FN_SRL:  w_alu = r_b >> w_shamt;
                    default: w_alu = '0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: w_alu = r_a + w_simm;
            OP_ANDI:               w_alu = r_a & w_zimm;
            OP_ORI:                w_alu = r_a | w_zimm;
            default:               w_alu = '0;
        endcase
    end

    // w_done marks the last cycle of an instruction; retire is its registered copy.
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (r_run && mem.imem_ready) begin
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_legal) begin
                    w_state_nxt = S_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    w_state_nxt = S_HALT;
`else
                    w_state_nxt = S_FETCH;
                    w_done      = 1'b1;
`endif
                end
            end
            S_EXEC: begin
                if (w_opcode == OP_BEQ) begin
                    w_state_nxt = S_FETCH;
                    w_done      = 1'b1;
                end else if ((w_opcode == OP_LW) || (w_opcode == OP_SW)) begin
                    w_state_nxt = S_MEM;
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_MEM: begin
                if (mem.dmem_ready) begin
                    if (w_opcode == OP_SW) begin
                        w_state_nxt = S_FETCH;
                        w_done      = 1'b1;
                    end else begin
                        w_state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                w_state_nxt = S_FETCH;
                w_done      = 1'b1;
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_FETCH;
            r_run    <= 1'b0;
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
            r_mdr    <= '0;
            r_retire <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_state  <= w_state_nxt;
            // Holds the first fetch request off until the first edge after reset release.
            r_run    <= 1'b1;
            r_retire <= w_done;
            case (r_state)
                S_FETCH: begin
                    if (r_run && mem.imem_ready) begin
                        r_ir <= mem.imem_rdata;
                        r_pc <= r_pc + XLEN'(PC_STEP);
                    end
                end
                S_DECODE: begin
                    r_a      <= r_regs[w_rs];
                    r_b      <= r_regs[w_rt];
                    // Branch target precomputed from the already-incremented PC.
                    r_aluout <= r_pc + (w_simm << 2);
                end
                S_EXEC: begin
                    if (w_opcode == OP_BEQ) begin
                        if (r_a == r_b) begin
                            r_pc <= r_aluout;
                        end
                    end else begin
                        r_aluout <= w_alu;
                    end
                end
                S_MEM: begin
                    if (mem.dmem_ready && (w_opcode == OP_LW)) begin
                        r_mdr <= mem.dmem_rdata;
                    end
                end
                S_WB: begin
                    // R0 is never written, so it always reads back zero.
                    if (w_wen && (w_dst != 5'd0)) begin
                        r_regs[w_dst] <= (w_opcode == OP_LW) ? r_mdr : r_aluout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem.imem_req   = (r_state == S_FETCH) && r_run;
    assign mem.imem_addr  = r_pc;
    assign mem.dmem_req   = (r_state == S_MEM);
    assign mem.dmem_we    = (r_state == S_MEM) && (w_opcode == OP_SW);
    assign mem.dmem_addr  = r_aluout;
    assign mem.dmem_wdata = r_b;

    assign pc_o   = r_pc;
    assign retire = r_retire;
`ifdef ILLEGAL_TRAP_EN
    assign halted = (r_state == S_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule
